// File: rtl/pll_pkg.sv
// Shared types and default sizing for the PLL phase/frequency detector.
package pll_pkg;

    localparam int unsigned PFD_ERR_W_DEF      = 11;
    localparam int unsigned PFD_LOCK_COUNT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } pfd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector; rise_o pulses
// for one clk cycle, on the third clk edge after d_i rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rise_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
            rise_q <= sync_q[1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/digital_pfd.sv
// Digital phase/frequency detector: measures clk cycles between paired ref/fb edges.
// Optional PFD_SLIP_COUNT_EN adds a saturating cycle-slip counter output.
module digital_pfd
    import pll_pkg::*;
#(
    parameter int unsigned ERR_W      = PFD_ERR_W_DEF,
    parameter int unsigned LOCK_COUNT = PFD_LOCK_COUNT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ref_in,
    input  logic                    fb_in,
    input  logic [7:0]              lock_window,
    output logic                    up,
    output logic                    dn,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    err_valid,
`ifdef PFD_SLIP_COUNT_EN
    output logic [7:0]              slip_count,
`endif
    output logic                    locked
);

    localparam int unsigned LCNT_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MAG_W  = (ERR_W > 8) ? ERR_W : 8;
    localparam logic [ERR_W-1:0]  CNT_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_COUNT);

    logic ref_rise;
    logic fb_rise;

    edge_sync u_ref_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ref_in),
        .rise_o (ref_rise)
    );

    edge_sync u_fb_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (fb_in),
        .rise_o (fb_rise)
    );

    pfd_state_t               state_q, state_d;
    logic [ERR_W-1:0]         cnt_q, cnt_d, cnt_inc;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic                     valid_q, valid_d;
    logic [LCNT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                     locked_q, locked_d;
    logic                     up_q, up_d;
    logic                     dn_q, dn_d;
    logic                     slip;
    logic [ERR_W-1:0]         close_mag;
    logic                     in_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    // Next state, measurement close-out and lock tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        slip       = 1'b0;
        close_mag  = '0;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ERR_W'(1);

        case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    valid_d = 1'b1;
                    err_d   = '0;
                end else if (ref_rise) begin
                    state_d = UP;
                    cnt_d   = ERR_W'(1);
                end else if (fb_rise) begin
                    state_d = DN;
                    cnt_d   = ERR_W'(1);
                end
            end
            UP: begin
                if (fb_rise) begin
                    valid_d   = 1'b1;
                    err_d     = $signed(cnt_q);
                    close_mag = cnt_q;
                    // A coincident ref edge opens the next measurement immediately.
                    state_d   = ref_rise ? UP : IDLE;
                    cnt_d     = ref_rise ? ERR_W'(1) : '0;
                end else if (ref_rise) begin
                    slip  = 1'b1;
                    cnt_d = ERR_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DN: begin
                if (ref_rise) begin
                    valid_d   = 1'b1;
                    err_d     = -$signed(cnt_q);
                    close_mag = cnt_q;
                    state_d   = fb_rise ? DN : IDLE;
                    cnt_d     = fb_rise ? ERR_W'(1) : '0;
                end else if (fb_rise) begin
                    slip  = 1'b1;
                    cnt_d = ERR_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        in_win = (MAG_W'(close_mag) <= MAG_W'(lock_window));

        if (slip || (valid_d && !in_win)) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            if (valid_d && (lock_cnt_q != LOCK_MAX)) begin
                lock_cnt_d = lock_cnt_q + LCNT_W'(1);
            end
            if (lock_cnt_q == LOCK_MAX) begin
                locked_d = 1'b1;
            end
        end

        up_d = (state_d == UP);
        dn_d = (state_d == DN);
    end

`ifdef PFD_SLIP_COUNT_EN
    logic [7:0] slip_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slip_cnt_q <= 8'd0;
        end else if (slip && (slip_cnt_q != 8'hFF)) begin
            slip_cnt_q <= slip_cnt_q + 8'd1;
        end
    end

    assign slip_count = slip_cnt_q;
`endif

    assign up        = up_q;
    assign dn        = dn_q;
    assign phase_err = err_q;
    assign err_valid = valid_q;
    assign locked    = locked_q;

endmodule
